pzcorebus_response_rate_sampler: RTL and testbench
==================================================

# pzcorebus_response_rate_sampler

Per-window rate sampler placed directly downstream of the corebus response counter in the debug/monitor path. It takes the counter's free-running count, measures the increment over a programmable window of L cycles, and presents each window's delta through a single-entry valid/ready output. It also tracks the peak delta since the last clear. It never clears the upstream counter, so software readers of the raw count remain undisturbed.

## Interface
Parameters:
- WIDTH, 16, width of the input count, delta and peak.
- WINDOW_WIDTH, 16, width of the window-length input and the internal timer.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_enable  input  1  run sampler; level-sensitive.
- i_window_length  input  WINDOW_WIDTH  window length L in cycles; value 0 is treated as 1; must be stable while i_enable=1.
- i_count  input  WIDTH  free-running response count from the upstream counter.
- i_max_clear  input  1  synchronous clear of o_max_delta.
- o_sample_valid  output  1  held sample is valid.
- i_sample_ready  input  1  consumer accepts the sample.
- o_sample_delta  output  WIDTH  count increment over the last completed window.
- o_sample_overrun  output  1  the held sample replaced an unaccepted one.
- o_max_delta  output  WIDTH  largest delta since reset or i_max_clear.
- o_busy  output  1  state != IDLE.

## Operation
- State machine IDLE, START, RUN. Reset state is IDLE.
  - IDLE -> START when i_enable=1.
  - START captures base <= i_count and timer <= 0, then goes to RUN. START always lasts 1 cycle.
  - RUN: timer increments each cycle.
  - Window end is the RUN cycle with timer == max(L,1)-1. On that cycle: delta = i_count - base, modulo 2^WIDTH; base <= i_count; timer <= 0.
  - Any state -> IDLE in the cycle after i_enable=0. A partial window is discarded and produces no sample.
- Wrap-around: the subtraction is modular, so counter wrap inside a window gives the correct delta. A true increment of 2^WIDTH or more within one window aliases. This is a usage constraint, not detected.
- Output register (single entry):
  - Window end while the register is empty, or being accepted in the same cycle: load delta, valid <= 1, overrun <= 0.
  - Window end while valid=1 and i_sample_ready=0: overwrite delta, overrun <= 1.
  - Acceptance (valid && ready) with no window end: valid <= 0. delta and overrun hold their values.
  - A held sample survives i_enable deassertion until it is accepted.
- Peak:
  - At window end: max <= (delta > max) ? delta : max.
  - i_max_clear alone: max <= 0.
  - i_max_clear on a window-end cycle: max <= delta. The clear takes precedence over the old value only.

## Timing
- Reset values: o_sample_valid=0, o_sample_delta=0, o_sample_overrun=0, o_max_delta=0, o_busy=0. Internal base=0, timer=0.
- i_enable rising at cycle c:
  - START at c+1.
  - First window end at c+1+L.
  - Outputs update at c+2+L, registered 1 cycle after window end.
- Steady state: one window end every L cycles. A sample appears every L cycles, and back-to-back L=1 samples are legal.
- i_count is sampled on START and window-end cycles only. The delta therefore counts i_count increments between consecutive sample edges.
- Valid/ready: o_sample_valid, delta and overrun change only on window end or acceptance. A consumer holding ready=1 never sees overrun.
- Asynchronous reset mid-window returns everything to reset values immediately. The pending sample is lost.

## Structure
- State enum local to the module; no new shared-package types needed. WIDTH arithmetic uses the existing pzcorebus_pkg conventions only.
- One sub-module: pzcorebus_window_timer. It holds the WINDOW_WIDTH timer, start/clear input and o_window_end pulse, with the L=0→1 mapping inside. It is reusable by other debug samplers.
- Top level contains the FSM, base register, subtractor, output register and peak tracker.

## Test plan
- Reset, then enable with L=4 and i_count incrementing every cycle from 0 -> first sample at enable+6 with delta=4 and overrun=0. Subsequent samples every 4 cycles with delta=4; o_max_delta=4.
- WIDTH=16, i_count stepping from 0xFFFE by 3 per window with L=8 -> delta=3 across the 0xFFFF→0x0001 wrap.
- Ready held 0 for two windows with deltas 5 then 7 -> held sample delta=7, overrun=1. Ready=1 then gives valid=0 the next cycle.
- i_max_clear on the same cycle as a window end with delta=2 while the peak is 9 -> o_max_delta=2. A later window with delta=6 gives 6.
- i_enable dropped mid-window (L=10 at timer=5) -> no sample, o_busy=0 the next cycle, and an earlier held sample is still valid. Re-enable restarts with a full 10-cycle window.
- L=0 with i_count incrementing by 1 per cycle -> a sample every cycle with delta=1. Async reset asserted mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/pzcorebus_response_rate_sampler_pkg.sv
// Shared defaults for the corebus response rate sampler and its window timer.
package pzcorebus_response_rate_sampler_pkg;
    localparam int unsigned SAMPLER_COUNT_WIDTH  = 16;
    localparam int unsigned SAMPLER_WINDOW_WIDTH = 16;
    localparam int unsigned SAMPLER_STATE_WIDTH  = 2;
endpackage

// File: rtl/pzcorebus_window_timer.sv
// Programmable window timer: o_window_end marks the last cycle of each L-cycle window (L=0 acts as 1).
module pzcorebus_window_timer
    import pzcorebus_response_rate_sampler_pkg::*;
#(
    parameter int unsigned WINDOW_WIDTH = SAMPLER_WINDOW_WIDTH
)(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_run,
    input  logic [WINDOW_WIDTH-1:0] i_window_length,
    output logic                    o_window_end
);
    logic [WINDOW_WIDTH-1:0] timer;
    logic [WINDOW_WIDTH-1:0] length_c;
    logic [WINDOW_WIDTH-1:0] last_c;
    logic                    window_end;

    always_comb begin
        length_c = (i_window_length == '0) ? WINDOW_WIDTH'(1) : i_window_length;
        last_c   = length_c - WINDOW_WIDTH'(1);
    end

    // The end flag is precomputed one cycle ahead so the pulse leaves a flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer      <= '0;
            window_end <= 1'b0;
        end else if (i_start) begin
            timer      <= '0;
            window_end <= (last_c == '0);
        end else if (i_run) begin
            if (window_end) begin
                timer      <= '0;
                window_end <= (last_c == '0);
            end else begin
                timer      <= timer + WINDOW_WIDTH'(1);
                window_end <= ((timer + WINDOW_WIDTH'(1)) == last_c);
            end
        end else begin
            window_end <= 1'b0;
        end
    end

    assign o_window_end = window_end;
endmodule

// File: rtl/pzcorebus_response_rate_sampler.sv
// Per-window rate sampler on the free-running corebus response count, with peak tracking.
module pzcorebus_response_rate_sampler
    import pzcorebus_response_rate_sampler_pkg::*;
#(
    parameter int unsigned WIDTH        = SAMPLER_COUNT_WIDTH,
    parameter int unsigned WINDOW_WIDTH = SAMPLER_WINDOW_WIDTH
)(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic [WINDOW_WIDTH-1:0] i_window_length,
    input  logic [WIDTH-1:0]        i_count,
    input  logic                    i_max_clear,
    output logic                    o_sample_valid,
    input  logic                    i_sample_ready,
    output logic [WIDTH-1:0]        o_sample_delta,
    output logic                    o_sample_overrun,
    output logic [WIDTH-1:0]        o_max_delta,
    output logic                    o_busy
);
    localparam logic [SAMPLER_STATE_WIDTH-1:0] IDLE  = 2'd0;
    localparam logic [SAMPLER_STATE_WIDTH-1:0] START = 2'd1;
    localparam logic [SAMPLER_STATE_WIDTH-1:0] RUN   = 2'd2;

    logic [SAMPLER_STATE_WIDTH-1:0] state;
    logic [SAMPLER_STATE_WIDTH-1:0] next_state;
    logic                           start_c;
    logic                           run_c;
    logic                           timer_end;
    logic                           window_end_c;
    logic [WIDTH-1:0]               base;
    logic [WIDTH-1:0]               delta_c;
    logic                           sample_valid;
    logic [WIDTH-1:0]               sample_delta;
    logic                           sample_overrun;
    logic [WIDTH-1:0]               max_delta;
    logic                           busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_c    = 1'b0;
        run_c      = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable) begin
                    next_state = START;
                end
            end
            START: begin
                start_c    = 1'b1;
                next_state = i_enable ? RUN : IDLE;
            end
            RUN: begin
                run_c = 1'b1;
                if (!i_enable) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    pzcorebus_window_timer #(
        .WINDOW_WIDTH   (WINDOW_WIDTH)
    ) u_window_timer (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (start_c),
        .i_run          (run_c),
        .i_window_length(i_window_length),
        .o_window_end   (timer_end)
    );

    // Modular subtraction keeps the delta correct across a counter wrap.
    always_comb begin
        window_end_c = run_c && timer_end;
        delta_c      = i_count - base;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            base <= '0;
            busy <= 1'b0;
        end else begin
            if (start_c || window_end_c) begin
                base <= i_count;
            end
            busy <= (next_state != IDLE);
        end
    end

    // Single-entry output register; an unaccepted sample is overwritten and flagged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sample_valid   <= 1'b0;
            sample_delta   <= '0;
            sample_overrun <= 1'b0;
        end else if (window_end_c) begin
            sample_valid   <= 1'b1;
            sample_delta   <= delta_c;
            sample_overrun <= sample_valid && !i_sample_ready;
        end else if (sample_valid && i_sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // A clear on a window-end cycle discards only the old peak, not the new delta.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            max_delta <= '0;
        end else if (window_end_c) begin
            if (i_max_clear || (delta_c > max_delta)) begin
                max_delta <= delta_c;
            end
        end else if (i_max_clear) begin
            max_delta <= '0;
        end
    end

    assign o_sample_valid   = sample_valid;
    assign o_sample_delta   = sample_delta;
    assign o_sample_overrun = sample_overrun;
    assign o_max_delta      = max_delta;
    assign o_busy           = busy;
endmodule

// File: tb/tb_pzcorebus_response_rate_sampler.sv
// Scoreboard bench for the response rate sampler: directed windows, monitor pops on every handshake.
module tb_pzcorebus_response_rate_sampler;
    localparam int unsigned WIDTH        = 16;
    localparam int unsigned WINDOW_WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] delta;
        logic             overrun;
        logic [WIDTH-1:0] max;
    } exp_t;

    logic                    i_clk = 1'b0;
    logic                    i_rst_n;
    logic                    i_enable;
    logic [WINDOW_WIDTH-1:0] i_window_length;
    logic [WIDTH-1:0]        i_count;
    logic                    i_max_clear;
    logic                    o_sample_valid;
    logic                    i_sample_ready;
    logic [WIDTH-1:0]        o_sample_delta;
    logic                    o_sample_overrun;
    logic [WIDTH-1:0]        o_max_delta;
    logic                    o_busy;

    exp_t             sb[$];
    int               checks   = 0;
    int               failures = 0;
    int               inc      = 0;
    logic [WIDTH-1:0] exp_max  = '0;

    pzcorebus_response_rate_sampler #(
        .WIDTH           (WIDTH),
        .WINDOW_WIDTH    (WINDOW_WIDTH)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_enable        (i_enable),
        .i_window_length (i_window_length),
        .i_count         (i_count),
        .i_max_clear     (i_max_clear),
        .o_sample_valid  (o_sample_valid),
        .i_sample_ready  (i_sample_ready),
        .o_sample_delta  (o_sample_delta),
        .o_sample_overrun(o_sample_overrun),
        .o_max_delta     (o_max_delta),
        .o_busy          (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        i_count = i_count + WIDTH'(inc);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Reference peak: updated for every completed window, accepted or not.
    task automatic model_window(input logic [WIDTH-1:0] d, input logic clr);
        exp_max = (clr || (d > exp_max)) ? d : exp_max;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic ovr);
        exp_t e;
        e.delta   = d;
        e.overrun = ovr;
        e.max     = exp_max;
        sb.push_back(e);
    endtask

    // Monitor: every accepted sample must match the oldest expected entry.
    always @(negedge i_clk) begin
        if (i_rst_n && o_sample_valid && i_sample_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample actual delta=0x%0h required none", o_sample_delta);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_delta", 32'(o_sample_delta), 32'(e.delta));
                check("sb_overrun", 32'(o_sample_overrun), 32'(e.overrun));
                check("sb_max", 32'(o_max_delta), 32'(e.max));
            end
        end
    end

    initial begin
        i_rst_n         = 1'b0;
        i_enable        = 1'b0;
        i_window_length = 16'd4;
        i_count         = '0;
        i_max_clear     = 1'b0;
        i_sample_ready  = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid", 32'(o_sample_valid), 32'd0);
        check("rst_delta", 32'(o_sample_delta), 32'd0);
        check("rst_overrun", 32'(o_sample_overrun), 32'd0);
        check("rst_max", 32'(o_max_delta), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        i_rst_n = 1'b1;
        tick();

        // L=4, count +1 per cycle: three samples of delta 4.
        i_count = '0;
        inc     = 1;
        repeat (3) begin
            model_window(16'd4, 1'b0);
            push(16'd4, 1'b0);
        end
        i_enable = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) check("t1_busy", 32'(o_busy), 32'd1);
            if (i == 5) check("t1_valid_early", 32'(o_sample_valid), 32'd0);
            if (i == 6) begin
                check("t1_valid_first", 32'(o_sample_valid), 32'd1);
                check("t1_max", 32'(o_max_delta), 32'd4);
            end
        end
        i_enable = 1'b0;
        tick();
        check("t1_busy_off", 32'(o_busy), 32'd0);

        // L=8, count 0xFFFE -> 0xFFFF -> 0x0001 -> 0x0004: delta 3 across the wrap.
        inc             = 0;
        i_count         = 16'hFFFE;
        i_window_length = 16'd8;
        repeat (2) begin
            model_window(16'd3, 1'b0);
            push(16'd3, 1'b0);
        end
        i_enable = 1'b1;
        ticks(2);
        i_count = 16'hFFFF;
        ticks(3);
        i_count = 16'h0001;
        ticks(5);
        check("t2_wrap_delta", 32'(o_sample_delta), 32'd3);
        i_count = 16'h0004;
        ticks(8);
        i_enable = 1'b0;
        tick();

        // Ready low for two windows (5 then 7): held sample is 7 with overrun.
        i_count         = 16'h0100;
        i_window_length = 16'd4;
        i_sample_ready  = 1'b0;
        model_window(16'd5, 1'b0);
        model_window(16'd7, 1'b0);
        push(16'd7, 1'b1);
        i_enable = 1'b1;
        ticks(2);
        i_count = i_count + 16'd5;
        ticks(4);
        check("t3_first_valid", 32'(o_sample_valid), 32'd1);
        check("t3_first_delta", 32'(o_sample_delta), 32'd5);
        check("t3_first_overrun", 32'(o_sample_overrun), 32'd0);
        i_count = i_count + 16'd7;
        ticks(4);
        check("t3_held_delta", 32'(o_sample_delta), 32'd7);
        check("t3_held_overrun", 32'(o_sample_overrun), 32'd1);
        i_enable       = 1'b0;
        i_sample_ready = 1'b1;
        tick();
        check("t3_valid_after_accept", 32'(o_sample_valid), 32'd0);
        check("t3_overrun_holds", 32'(o_sample_overrun), 32'd1);

        // Peak 9, then clear coincident with a delta-2 window end, then delta 6.
        model_window(16'd9, 1'b0);
        push(16'd9, 1'b0);
        model_window(16'd2, 1'b1);
        push(16'd2, 1'b0);
        model_window(16'd6, 1'b0);
        push(16'd6, 1'b0);
        i_enable = 1'b1;
        ticks(2);
        i_count = i_count + 16'd9;
        ticks(4);
        check("t4_peak9", 32'(o_max_delta), 32'd9);
        i_count = i_count + 16'd2;
        ticks(3);
        i_max_clear = 1'b1;
        tick();
        i_max_clear = 1'b0;
        check("t4_clear_on_end", 32'(o_max_delta), 32'd2);
        i_count = i_count + 16'd6;
        ticks(4);
        check("t4_peak6", 32'(o_max_delta), 32'd6);
        i_enable = 1'b0;
        tick();

        // L=10, held sample survives a mid-window disable; re-enable runs a full window.
        inc             = 1;
        i_window_length = 16'd10;
        i_sample_ready  = 1'b0;
        model_window(16'd10, 1'b0);
        push(16'd10, 1'b0);
        i_enable = 1'b1;
        ticks(12);
        check("t5_held_valid", 32'(o_sample_valid), 32'd1);
        ticks(5);
        i_enable = 1'b0;
        tick();
        check("t5_busy_off", 32'(o_busy), 32'd0);
        check("t5_still_valid", 32'(o_sample_valid), 32'd1);
        check("t5_still_delta", 32'(o_sample_delta), 32'd10);
        ticks(3);
        check("t5_no_partial", 32'(o_sample_overrun), 32'd0);
        i_sample_ready = 1'b1;
        tick();
        check("t5_drained", 32'(o_sample_valid), 32'd0);
        model_window(16'd10, 1'b0);
        push(16'd10, 1'b0);
        i_enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 11) check("t5_restart_early", 32'(o_sample_valid), 32'd0);
            if (i == 12) check("t5_restart_valid", 32'(o_sample_valid), 32'd1);
        end
        i_enable = 1'b0;
        tick();

        // L=0 behaves as L=1: back-to-back delta-1 samples, then async reset mid-run.
        i_window_length = 16'd0;
        repeat (5) begin
            model_window(16'd1, 1'b0);
            push(16'd1, 1'b0);
        end
        i_enable = 1'b1;
        ticks(7);
        check("t6_valid", 32'(o_sample_valid), 32'd1);
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(o_sample_valid), 32'd0);
        check("t6_rst_delta", 32'(o_sample_delta), 32'd0);
        check("t6_rst_overrun", 32'(o_sample_overrun), 32'd0);
        check("t6_rst_max", 32'(o_max_delta), 32'd0);
        check("t6_rst_busy", 32'(o_busy), 32'd0);
        exp_max  = '0;
        i_enable = 1'b0;
        tick();
        i_rst_n = 1'b1;
        ticks(2);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
